rc4_prga: RTL
=============

# rc4_prga

RC4 keystream generator (pseudo-random generation algorithm) for the nibble-wide RC4 datapath. Holds the 2^W-entry S-box, accepts an externally computed key schedule through a write port, then on demand steps i/j, swaps S[i]/S[j] and emits one keystream word per step over a valid/ready handshake. It is the consumer side of the S-box state produced by the key-scheduling/swap logic, and it feeds the XOR stage of the cipher.

## Interface
- W, 4, word width; S-box depth is 2^W entries of W bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- load_en  input  1  write S[load_addr] <= load_data; honoured only in IDLE.
- load_addr  input  W  S-box write index.
- load_data  input  W  S-box write value.
- run  input  1  level; generation proceeds while high.
- ks_data  output  W  keystream word, registered.
- ks_valid  output  1  ks_data valid.
- ks_ready  input  1  consumer accepts ks_data when ks_valid & ks_ready.
- busy  output  1  high in every state except IDLE.

## Operation
- State: S[0..2^W-1], index registers i, j (W bits each), FSM {IDLE, STEP, SWAP, KS, HOLD}.
- Reset: S[k]=k (identity), i=j=0, ks_data=0, ks_valid=0, busy=0, FSM=IDLE.
- IDLE: load_en writes S[load_addr]; any load write also clears i and j to 0. If run=1 and load_en=0 -> STEP. Simultaneous load_en and run: the load wins; STEP entered next cycle if run still high.
- STEP: i <= i+1; j <= j + S[i+1] (all arithmetic mod 2^W, natural W-bit wrap) -> SWAP.
- SWAP: S[i] <= S[j], S[j] <= S[i] in one cycle; i==j leaves S unchanged -> KS.
- KS: ks_data <= S[(S[i]+S[j]) mod 2^W] using post-swap values; ks_valid <= 1 -> HOLD.
- HOLD: ks_data/ks_valid stable until ks_ready. On ks_valid & ks_ready: ks_valid <= 0; next state STEP if run=1, else IDLE.
- Dropping run mid-step does not abort: the pending word completes and is held until accepted; only then does the FSM return to IDLE. i, j and S are preserved across IDLE, so resuming continues the same keystream.
- load_en outside IDLE is ignored (no write, no i/j clear).
- Reset asserted in any state returns immediately to reset values; in-flight word is discarded.

## Timing
- run sampled high in IDLE at edge N: ks_valid high after edge N+3 (STEP N+1, SWAP N+2, KS N+3 -> HOLD).
- Steady state with ks_ready=1 and run=1: one word per 4 cycles (HOLD->STEP->SWAP->KS->HOLD).
- ks_ready is a don't-care while ks_valid=0; no combinational path from ks_ready to ks_valid or ks_data.
- Load write takes effect on the same edge; S readable by STEP the following cycle.

## Structure
- Shared package rc4_pkg: W default (4), SBOX_N = 2^W, FSM state enum (IDLE, STEP, SWAP, KS, HOLD).
- One sub-module rc4_sbox: 2^W x W register file, identity reset, one write port (load), combinational read ports for S[i+1], S[i], S[j], S[t], and a dual-address swap strobe. rc4_prga holds the FSM, i/j and output registers.

## Test plan
- Reset, no load, run=1, ks_ready=1 -> first three words 2, 5, 7; first ks_valid 3 cycles after run sampled; words spaced 4 cycles.
- Load S[k]=15-k for all k, run=1 -> first word: i=1, j=14, swap S1/S14 (S1=1, S14=14), ks=S[15]=0; check against reference model for 40 words including i wrap 15->0.
- ks_ready held low 10 cycles while ks_valid=1 -> ks_data and ks_valid stable throughout; accepted word is the one first presented.
- run dropped during SWAP -> word still emitted, FSM returns to IDLE after acceptance, busy=0; run reasserted -> sequence continues without repetition or gap versus model.
- load_en pulsed during STEP/HOLD -> S and i/j unchanged; load in IDLE mid-sequence -> i=j=0, next word computed from new S.
- reset driven low in HOLD -> ks_valid=0, busy=0, S identity, i=j=0 asynchronously; after release, run=1 reproduces 2, 5, 7.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg
// Shared definitions for the nibble-wide RC4 keystream generator:
//   W        - datapath word width (S-box entries and indices)
//   SBOX_N   - number of S-box entries (2^W)
//   sbox_t   - packed S-box image, entry k in sbox_t[k]
//   state_t  - PRGA sequencing states
//   sbox_identity() - S-box image with S[k] = k, the reset contents
package rc4_pkg;

    localparam int W      = 4;
    localparam int SBOX_N = 1 << W;

    typedef logic [SBOX_N-1:0][W-1:0] sbox_t;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        SWAP,
        KS,
        HOLD
    } state_t;

    // Builds the identity permutation that the S-box wakes up with.
    function automatic sbox_t sbox_identity();
        sbox_t s;
        for (int k = 0; k < SBOX_N; k++) begin
            s[k] = W'(k);
        end
        return s;
    endfunction

endpackage

// File: rtl/rc4_prga_if.sv
// rc4_prga_if
// Bundles the load port, the run control and the keystream handshake of
// the RC4 keystream generator.
//   load_en/load_addr/load_data - S-box write from the key scheduler
//   run                         - level request to keep generating words
//   ks_data/ks_valid/ks_ready   - keystream word handshake
//   busy                        - generator is not idle
// Modports: master drives loads, run and ks_ready; slave is the generator.
interface rc4_prga_if;
    import rc4_pkg::*;

    logic         load_en;
    logic [W-1:0] load_addr;
    logic [W-1:0] load_data;
    logic         run;
    logic [W-1:0] ks_data;
    logic         ks_valid;
    logic         ks_ready;
    logic         busy;

    modport master (
        output load_en, load_addr, load_data, run, ks_ready,
        input  ks_data, ks_valid, busy
    );

    modport slave (
        input  load_en, load_addr, load_data, run, ks_ready,
        output ks_data, ks_valid, busy
    );

endinterface

// File: rtl/rc4_sbox.sv
// rc4_sbox
// 2^W x W register file holding the RC4 permutation.
//   clk, reset        - clock and asynchronous active-low reset (identity)
//   wr_en/addr/data   - single write port used by the key loader
//   swap_en/a/b       - exchanges S[a] and S[b] in one cycle
//   rdN_addr/rdN_data - four combinational read ports
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         swap_en,
    input  logic [W-1:0] swap_a,
    input  logic [W-1:0] swap_b,
    input  logic [W-1:0] rd0_addr,
    output logic [W-1:0] rd0_data,
    input  logic [W-1:0] rd1_addr,
    output logic [W-1:0] rd1_data,
    input  logic [W-1:0] rd2_addr,
    output logic [W-1:0] rd2_data,
    input  logic [W-1:0] rd3_addr,
    output logic [W-1:0] rd3_data
);

    sbox_t sbox_q;
    sbox_t sbox_d;

    assign rd0_data = sbox_q[rd0_addr];
    assign rd1_data = sbox_q[rd1_addr];
    assign rd2_data = sbox_q[rd2_addr];
    assign rd3_data = sbox_q[rd3_addr];

    // Next S-box image. Both swap writes read the old contents, so equal
    // swap indices naturally leave the entry untouched. The controller
    // never asks for a write and a swap together; the write takes priority.
    always_comb begin
        sbox_d = sbox_q;
        if (wr_en) begin
            sbox_d[wr_addr] = wr_data;
        end else if (swap_en) begin
            sbox_d[swap_a] = sbox_q[swap_b];
            sbox_d[swap_b] = sbox_q[swap_a];
        end
    end

    // S-box storage, reset to the identity permutation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sbox_q <= sbox_identity();
        end else begin
            sbox_q <= sbox_d;
        end
    end

endmodule

// File: rtl/rc4_prga.sv
// rc4_prga
// RC4 pseudo-random generation: steps i/j, swaps S[i]/S[j] and presents one
// registered keystream word per step over a valid/ready handshake.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - rc4_prga_if slave: S-box load port, run, keystream handshake, busy
module rc4_prga
    import rc4_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    rc4_prga_if.slave bus
);

    state_t       state_q, state_d;
    logic [W-1:0] i_q, i_d;
    logic [W-1:0] j_q, j_d;
    logic [W-1:0] ks_data_q, ks_data_d;
    logic         ks_valid_q, ks_valid_d;

    logic         wr_en;
    logic         swap_en;
    logic [W-1:0] i_next;
    logic [W-1:0] t_idx;
    logic [W-1:0] s_inext;
    logic [W-1:0] s_i;
    logic [W-1:0] s_j;
    logic [W-1:0] s_t;

    assign i_next = i_q + 1'b1;
    assign t_idx  = s_i + s_j;

    rc4_sbox u_sbox (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (bus.load_addr),
        .wr_data  (bus.load_data),
        .swap_en  (swap_en),
        .swap_a   (i_q),
        .swap_b   (j_q),
        .rd0_addr (i_next),
        .rd0_data (s_inext),
        .rd1_addr (i_q),
        .rd1_data (s_i),
        .rd2_addr (j_q),
        .rd2_data (s_j),
        .rd3_addr (t_idx),
        .rd3_data (s_t)
    );

    // Sequencer: IDLE accepts loads (a load beats run), STEP advances the
    // indices, SWAP exchanges S[i]/S[j], KS looks up the word from the
    // already-swapped entries, and HOLD keeps the word until it is taken.
    // run is only consulted in IDLE and at acceptance, so dropping it
    // mid-step still delivers the pending word.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        ks_data_d  = ks_data_q;
        ks_valid_d = ks_valid_q;
        wr_en      = 1'b0;
        swap_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_en) begin
                    wr_en = 1'b1;
                    i_d   = '0;
                    j_d   = '0;
                end else if (bus.run) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                i_d     = i_next;
                j_d     = j_q + s_inext;
                state_d = SWAP;
            end
            SWAP: begin
                swap_en = 1'b1;
                state_d = KS;
            end
            KS: begin
                ks_data_d  = s_t;
                ks_valid_d = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (ks_valid_q && bus.ks_ready) begin
                    ks_valid_d = 1'b0;
                    state_d    = bus.run ? STEP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            ks_data_q  <= ks_data_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    assign bus.ks_data  = ks_data_q;
    assign bus.ks_valid = ks_valid_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
